// File: rtl/cmplx_mult_seq.sv
// rtl/cmplx_mult_seq.sv - four-cycle complex multiply sequencer over one shared real multiplier

module cmplx_mult_seq #(
    parameter int WORD_SIZE = 37,
    parameter int HALF_SIZE = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] a_re,
    input  logic [WORD_SIZE-1:0] a_im,
    input  logic [WORD_SIZE-1:0] b_re,
    input  logic [WORD_SIZE-1:0] b_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] c_re,
    output logic [WORD_SIZE-1:0] c_im,
    output logic [WORD_SIZE-1:0] mult_a,
    output logic [WORD_SIZE-1:0] mult_b,
    input  logic [WORD_SIZE-1:0] mult_c
);

    if (HALF_SIZE <= 0 || HALF_SIZE >= WORD_SIZE) begin : g_bad_format
        $error("cmplx_mult_seq: HALF_SIZE must lie strictly between 0 and WORD_SIZE");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [WORD_SIZE-1:0] a_re_q;
    logic [WORD_SIZE-1:0] a_im_q;
    logic [WORD_SIZE-1:0] b_re_q;
    logic [WORD_SIZE-1:0] b_im_q;
    logic [WORD_SIZE-1:0] acc_re;
    logic [WORD_SIZE-1:0] acc_im;

    // Shared multiplier operands are forced to zero outside M0..M3 so it never toggles idle.
    always_comb begin
        state_next = state;
        mult_a     = '0;
        mult_b     = '0;
        case (state)
            IDLE: begin
                if (in_valid) state_next = M0;
            end
            M0: begin
                mult_a     = a_re_q;
                mult_b     = b_re_q;
                state_next = M1;
            end
            M1: begin
                mult_a     = a_im_q;
                mult_b     = b_im_q;
                state_next = M2;
            end
            M2: begin
                mult_a     = a_re_q;
                mult_b     = b_im_q;
                state_next = M3;
            end
            M3: begin
                mult_a     = a_im_q;
                mult_b     = b_re_q;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
            acc_re <= '0;
            acc_im <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                b_re_q <= b_re;
                b_im_q <= b_im;
            end
            // Accumulation wraps modulo 2^WORD_SIZE; no saturation.
            case (state)
                M0:      acc_re <= mult_c;
                M1:      acc_re <= acc_re - mult_c;
                M2:      acc_im <= mult_c;
                M3:      acc_im <= acc_im + mult_c;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign c_re      = acc_re;
    assign c_im      = acc_im;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// tb/tb_cmplx_mult_seq.sv - directed self-checking bench for cmplx_mult_seq

module tb_cmplx_mult_seq;

    localparam int W = 37;
    localparam int H = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c_re, c_im;
    logic [W-1:0] mult_a, mult_b, mult_c;

    logic signed [2*W-1:0] prod;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Reference double_sign_mult: full signed product, Q-format rescale by truncation.
    always_comb begin
        prod   = $signed(mult_a) * $signed(mult_b);
        mult_c = prod[W+H-1:H];
    end

    cmplx_mult_seq #(.WORD_SIZE(W), .HALF_SIZE(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_re      (c_re),
        .c_im      (c_im),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_c    (mult_c)
    );

    function automatic logic [W-1:0] fx(input longint v);
        logic signed [63:0] t;
        t = v <<< H;
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operand set through M0..M3 into DONE; unless hold, completes the handshake.
    task automatic run_txn(input string tag, input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [W-1:0] br, input logic [W-1:0] bi,
                           input logic [W-1:0] er, input logic [W-1:0] ei, input bit hold);
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        in_valid  = 1'b1;
        out_ready = !hold;
        check({tag, "/idle_in_ready"}, in_ready, 1);
        check({tag, "/idle_mult_a"}, mult_a, 0);
        check({tag, "/idle_mult_b"}, mult_b, 0);
        tick();
        in_valid = 1'b0;
        a_re = fx(100); a_im = fx(-77); b_re = fx(33); b_im = fx(5);
        check({tag, "/m0_mult_a"}, mult_a, ar);
        check({tag, "/m0_mult_b"}, mult_b, br);
        check({tag, "/m0_in_ready"}, in_ready, 0);
        tick();
        check({tag, "/m1_mult_a"}, mult_a, ai);
        check({tag, "/m1_mult_b"}, mult_b, bi);
        tick();
        check({tag, "/m2_mult_a"}, mult_a, ar);
        check({tag, "/m2_mult_b"}, mult_b, bi);
        tick();
        check({tag, "/m3_mult_a"}, mult_a, ai);
        check({tag, "/m3_mult_b"}, mult_b, br);
        check({tag, "/m3_out_valid"}, out_valid, 0);
        tick();
        check({tag, "/done_out_valid"}, out_valid, 1);
        check({tag, "/done_c_re"}, c_re, er);
        check({tag, "/done_c_im"}, c_im, ei);
        check({tag, "/done_in_ready"}, in_ready, 0);
        check({tag, "/done_mult_a"}, mult_a, 0);
        check({tag, "/done_mult_b"}, mult_b, 0);
        if (!hold) begin
            tick();
            check({tag, "/post_out_valid"}, out_valid, 0);
            check({tag, "/post_in_ready"}, in_ready, 1);
            check({tag, "/post_c_re"}, c_re, er);
            check({tag, "/post_c_im"}, c_im, ei);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] half, nhalf, wrap_re;
        half    = 37'h20000;
        nhalf   = '0 - half;
        wrap_re = 37'h1000000000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_re = fx(9); a_im = fx(9); b_re = fx(9); b_im = fx(9);
        tick();
        tick();
        rst = 1'b0;
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/c_re", c_re, 0);
        check("reset/c_im", c_im, 0);
        check("reset/mult_a", mult_a, 0);
        check("reset/mult_b", mult_b, 0);

        run_txn("basic", fx(2), fx(1), fx(3), fx(-1), fx(7), fx(1), 1'b0);
        run_txn("frac", half, half, half, nhalf, half, '0, 1'b0);
        run_txn("mixed", fx(-3), fx(4), fx(2), fx(5), fx(-26), fx(-7), 1'b0);

        run_txn("bp", fx(1), fx(2), fx(1), fx(1), fx(-1), fx(3), 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_re = fx(i + 11);
            tick();
            check("bp/out_valid", out_valid, 1);
            check("bp/c_re", c_re, fx(-1));
            check("bp/c_im", c_im, fx(3));
            check("bp/in_ready", in_ready, 0);
            check("bp/mult_a", mult_a, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp/release_out_valid", out_valid, 0);
        check("bp/release_in_ready", in_ready, 1);
        check("bp/release_c_re", c_re, fx(-1));

        a_re = fx(2); a_im = fx(1); b_re = fx(3); b_im = fx(-1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rstmid/m2_mult_b", mult_b, fx(-1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid/out_valid", out_valid, 0);
        check("rstmid/in_ready", in_ready, 1);
        check("rstmid/c_re", c_re, 0);
        check("rstmid/c_im", c_im, 0);
        check("rstmid/mult_a", mult_a, 0);
        run_txn("rstmid_after", fx(2), fx(1), fx(3), fx(-1), fx(7), fx(1), 1'b0);

        run_txn("wrap", fx(512), '0, fx(512), '0, wrap_re, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
